// File: rtl/demux_stream_1_n.sv
// demux_stream_1_n: registered valid/ready 1:N stream demultiplexer.
// One input stream is steered into CHANNELS one-entry holding slots. The target
// is Select_In (addressed mode) or an internal rotating pointer (round-robin).
// Each slot drains independently through its own valid/ready pair.
// Optional feature macro: DEMUX_DROP_COUNT_EN adds a 16-bit saturating
// dropped-beat counter on Drop_Count_Out.
// Ports:
//   Clock_In, Reset_n_In (synchronous, active-low)
//   Enable_In, Mode_In (0 addressed / 1 round-robin)
//   Valid_In, Ready_Out, Data_In, Select_In     : input stream
//   DEMUX_Valid_Out, DEMUX_Ready_In, DEMUX_Data_Out : per-channel streams
//   Drop_Pulse_Out                             : out-of-range beat discarded
//   Drop_Count_Out                             : dropped-beat count (optional)
module demux_stream_1_n #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned SEL_WIDTH  = $clog2(CHANNELS)
) (
  input  logic                           Clock_In,
  input  logic                           Reset_n_In,
  input  logic                           Enable_In,
  input  logic                           Mode_In,
  input  logic                           Valid_In,
  output logic                           Ready_Out,
  input  logic [DATA_WIDTH-1:0]          Data_In,
  input  logic [SEL_WIDTH-1:0]           Select_In,
  output logic [CHANNELS-1:0]            DEMUX_Valid_Out,
  input  logic [CHANNELS-1:0]            DEMUX_Ready_In,
  output logic [CHANNELS*DATA_WIDTH-1:0] DEMUX_Data_Out,
`ifdef DEMUX_DROP_COUNT_EN
  output logic [15:0]                    Drop_Count_Out,
`endif
  output logic                           Drop_Pulse_Out
);

  localparam int unsigned CNT_W = 16;

  logic [SEL_WIDTH-1:0]                 rr_ptr;
  logic [CHANNELS-1:0]                  valid_q;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  data_q;
  logic                                 drop_pulse_q;

  logic [SEL_WIDTH-1:0]                 target_c;
  logic                                 in_range_c;
  logic                                 busy_c;
  logic                                 accept_c;
  logic [CHANNELS-1:0]                  load_c;

  // Target selection and range check.
  assign target_c   = Mode_In ? rr_ptr : Select_In;
  assign in_range_c = (32'(target_c) < CHANNELS);

  // Per-slot load decode; busy when the target slot is full and not draining.
  // Loop-based decode avoids indexing past CHANNELS for out-of-range targets.
  always_comb begin
    busy_c = 1'b0;
    load_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (target_c == SEL_WIDTH'(k)) begin
        busy_c    = valid_q[k] & ~DEMUX_Ready_In[k];
        load_c[k] = accept_c;
      end
    end
  end

  assign Ready_Out = Enable_In & ~busy_c;
  assign accept_c  = Valid_In & Ready_Out;

  // Holding slots: a load in the same cycle as a drain keeps the slot full.
  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        valid_q[k] <= load_c[k] | (valid_q[k] & ~DEMUX_Ready_In[k]);
        if (load_c[k]) begin
          data_q[k] <= Data_In;
        end
      end
    end
  end

  // Round-robin pointer advances only on accepted beats in round-robin mode.
  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) begin
      rr_ptr <= '0;
    end else if (accept_c && Mode_In) begin
      rr_ptr <= (rr_ptr == SEL_WIDTH'(CHANNELS - 1)) ? '0 : rr_ptr + SEL_WIDTH'(1);
    end
  end

  // Drop indication for accepted out-of-range beats.
  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) begin
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= accept_c & ~in_range_c;
    end
  end

`ifdef DEMUX_DROP_COUNT_EN
  logic [CNT_W-1:0] drop_cnt_q;

  // Saturating dropped-beat counter.
  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) begin
      drop_cnt_q <= '0;
    end else if (accept_c && !in_range_c && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign Drop_Count_Out = drop_cnt_q;
`endif

  assign DEMUX_Valid_Out = valid_q;
  assign DEMUX_Data_Out  = data_q;
  assign Drop_Pulse_Out  = drop_pulse_q;

endmodule

// File: tb/tb_demux_stream_1_n.sv
// Testbench for demux_stream_1_n (CHANNELS=6 so out-of-range selects exist).
// A per-cycle array model tracks slot contents, the round-robin pointer and
// drop state; directed scenarios are followed by randomized traffic.
module tb_demux_stream_1_n;

  localparam int unsigned DW = 8;
  localparam int unsigned CH = 6;
  localparam int unsigned SW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              mode;
  logic              vld;
  logic              rdy_out;
  logic [DW-1:0]     din;
  logic [SW-1:0]     sel;
  logic [CH-1:0]     ch_valid;
  logic [CH-1:0]     ch_ready;
  logic [CH*DW-1:0]  ch_data;
  logic              drop_pulse;
`ifdef DEMUX_DROP_COUNT_EN
  logic [15:0]       drop_count;
`endif

  always #5 clk = ~clk;

  demux_stream_1_n #(.DATA_WIDTH(DW), .CHANNELS(CH), .SEL_WIDTH(SW)) u_dut (
    .Clock_In        (clk),
    .Reset_n_In      (rst_n),
    .Enable_In       (en),
    .Mode_In         (mode),
    .Valid_In        (vld),
    .Ready_Out       (rdy_out),
    .Data_In         (din),
    .Select_In       (sel),
    .DEMUX_Valid_Out (ch_valid),
    .DEMUX_Ready_In  (ch_ready),
    .DEMUX_Data_Out  (ch_data),
`ifdef DEMUX_DROP_COUNT_EN
    .Drop_Count_Out  (drop_count),
`endif
    .Drop_Pulse_Out  (drop_pulse)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit [7:0] m_data [CH];
  bit       m_valid[CH];
  int       m_rr;
  bit       m_drop;
  int       m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < int'(CH); k++) begin
      m_data[k]  = 8'h00;
      m_valid[k] = 1'b0;
    end
    m_rr   = 0;
    m_drop = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit r, input bit e, input bit m, input bit v,
                      input bit [7:0] d, input bit [2:0] s, input bit [5:0] rdy);
    int            t;
    bit            busy;
    bit            exp_rdy;
    logic [CH-1:0]    ev;
    logic [CH*DW-1:0] ed;
    @(negedge clk);
    rst_n = r; en = e; mode = m; vld = v; din = d; sel = s; ch_ready = rdy;
    #1;
    t       = m ? m_rr : int'(s);
    busy    = (t < int'(CH)) ? (m_valid[t] && !rdy[t]) : 1'b0;
    exp_rdy = e && !busy;
    for (int k = 0; k < int'(CH); k++) begin
      ev[k]         = m_valid[k];
      ed[k*DW +: DW] = m_data[k];
    end
    check("valid_out", 64'(ch_valid), 64'(ev));
    check("data_out", 64'(ch_data), 64'(ed));
    check("drop_pulse", 64'(drop_pulse), 64'(m_drop));
`ifdef DEMUX_DROP_COUNT_EN
    check("drop_count", 64'(drop_count), 64'(m_cnt));
`endif
    if (r) check("ready_out", 64'(rdy_out), 64'(exp_rdy));
    if (!r) begin
      model_reset();
    end else begin
      for (int k = 0; k < int'(CH); k++)
        if (m_valid[k] && rdy[k]) m_valid[k] = 1'b0;
      m_drop = 1'b0;
      if (v && exp_rdy) begin
        if (t < int'(CH)) begin
          m_valid[t] = 1'b1;
          m_data[t]  = d;
        end else begin
          m_drop = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
        if (m) m_rr = (m_rr + 1) % int'(CH);
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; vld = 1'b0;
    din = '0; sel = '0; ch_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Addressed fill, then back-pressure on a full slot.
    step(1, 1, 0, 1, 8'hA5, 3, 6'b000000);
    settle();
    check("fill_valid", 64'(ch_valid), 64'(6'b001000));
    check("fill_data", 64'(ch_data[3*DW +: DW]), 64'(8'hA5));
    step(1, 1, 0, 1, 8'h5A, 3, 6'b000000);
    check("fill_block", 64'(rdy_out), 64'(0));
    step(1, 1, 0, 1, 8'h5A, 3, 6'b001000);
    check("fill_refill", 64'(rdy_out), 64'(1));

    // Full throughput on channel 5.
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 1, 8'(i), 5, 6'b100000);
      check("tput_ready", 64'(rdy_out), 64'(1));
    end
    step(1, 1, 0, 0, 8'h00, 0, 6'b111111);

    // Round-robin wrap, then a mode toggle must keep the pointer.
    for (int i = 0; i < 10; i++) step(1, 1, 1, 1, 8'(8'h10 + i), 0, 6'b111111);
    step(1, 1, 0, 0, 8'h00, 0, 6'b111111);
    step(1, 1, 1, 1, 8'h77, 0, 6'b000000);
    settle();
    check("rr_retain", 64'(ch_valid), 64'(6'b010000));
    step(1, 1, 0, 0, 8'h00, 0, 6'b111111);

    // Out-of-range drops.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 8'hE0, 7, 6'b000000);
      check("drop_ready", 64'(rdy_out), 64'(1));
    end
    settle();
    check("drop_pulse_hi", 64'(drop_pulse), 64'(1));
    check("drop_no_slot", 64'(ch_valid), 64'(0));
`ifdef DEMUX_DROP_COUNT_EN
    check("drop_cnt3", 64'(drop_count), 64'(3));
`endif

    // Enable gating; held beat still drains.
    step(1, 1, 0, 1, 8'h3C, 2, 6'b000000);
    step(1, 0, 0, 1, 8'h99, 2, 6'b000000);
    check("en_block", 64'(rdy_out), 64'(0));
    step(1, 0, 0, 1, 8'h99, 2, 6'b000100);
    settle();
    check("en_drain", 64'(ch_valid), 64'(0));

    // Reset mid-operation.
    step(1, 1, 0, 1, 8'h11, 0, 6'b000000);
    step(1, 1, 0, 1, 8'h44, 4, 6'b000000);
    step(1, 1, 1, 1, 8'h55, 0, 6'b000000);
    step(0, 1, 1, 1, 8'h66, 0, 6'b000000);
    settle();
    check("rst_valid", 64'(ch_valid), 64'(0));
    check("rst_data", 64'(ch_data), 64'(0));
    step(1, 1, 1, 1, 8'hEE, 0, 6'b000000);
    settle();
    check("rst_rr_ch0", 64'(ch_valid), 64'(6'b000001));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 64) != 0, ($urandom % 8) != 0, 1'($urandom), ($urandom % 4) != 0,
           8'($urandom), 3'($urandom_range(0, 7)), 6'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_stream_1_n.md
# demux_stream_1_n

Registered, handshaked 1:N stream demultiplexer; the parametrised successor of the combinational 1:8 DEMUX. It steers DATA_WIDTH-bit beats from one valid/ready input to one of CHANNELS output channels. Steering is either by Select_In (addressed mode) or by an internal rotating pointer (round-robin mode). Each channel has a one-entry holding register so downstream consumers can stall independently; sits between a single producer and per-channel consumers in the data-selector library.

## Interface
- DATA_WIDTH, 8, beat width in bits (≥1)
- CHANNELS, 8, output channel count (2..64; need not be a power of 2)
- SEL_WIDTH, $clog2(CHANNELS), Select_In width
- Clock_In  input  1  single clock; all state updates on rising edge
- Reset_n_In  input  1  reset, synchronous, active-low
- Enable_In  input  1  1 = block may accept beats; 0 = Ready_Out forced 0 (held beats still drain)
- Mode_In  input  1  0 = addressed (Select_In), 1 = round-robin
- Valid_In  input  1  input beat valid
- Ready_Out  output  1  input beat accepted when Valid_In && Ready_Out
- Data_In  input  DATA_WIDTH  input beat
- Select_In  input  SEL_WIDTH  target channel in addressed mode
- DEMUX_Valid_Out  output  CHANNELS  bit k = channel k holds a beat
- DEMUX_Ready_In  input  CHANNELS  bit k = consumer k takes beat this cycle
- DEMUX_Data_Out  output  CHANNELS*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- Drop_Pulse_Out  output  1  one-cycle pulse, an out-of-range beat was discarded
- Drop_Count_Out  output  16  dropped-beat count (present only with DEMUX_DROP_COUNT_EN)

## Operation
- Target T = (Mode_In ? rr_ptr : Select_In), evaluated combinationally each cycle.
- Channel k transfer out: DEMUX_Valid_Out[k] && DEMUX_Ready_In[k]; on transfer, the slot empties unless refilled in the same cycle.
- Ready_Out = Enable_In && (T out of range || !DEMUX_Valid_Out[T] || DEMUX_Ready_In[T]). The combinational path from DEMUX_Ready_In to Ready_Out is permitted.
- Accepted beat, T in range: slot T loads Data_In, valid set. Simultaneous drain and refill of the same slot gives full throughput, and valid stays 1.
- Accepted beat, T ≥ CHANNELS (addressed mode only): beat discarded, no slot changes, Drop_Pulse_Out = 1 next cycle.
- rr_ptr: SEL_WIDTH bits, advances on every accepted beat in mode 1; wraps CHANNELS-1 → 0. It holds in mode 0 and across mode changes.
- Non-target slots are unaffected by input acceptance. Their data holds while valid; data of empty slots is don't-care but held (no X injection).
- Enable_In = 0: no acceptance and rr_ptr holds; outputs remain driven (no high-Z, unlike the combinational predecessor).

## Timing
- Latency: beat accepted at edge n → DEMUX_Valid_Out[T] = 1 and data visible after edge n (cycle n+1).
- Drop_Pulse_Out high exactly one cycle after each discarding edge; back-to-back drops keep it high.
- Reset (Reset_n_In = 0 at a rising edge), including mid-stream: all DEMUX_Valid_Out = 0, DEMUX_Data_Out = 0, rr_ptr = 0, Drop_Pulse_Out = 0, Drop_Count_Out = 0. Held beats are lost.
- During reset Ready_Out may be evaluated but no acceptance occurs.
- Mode_In and Select_In are sampled only at the accepting edge; changing them while Valid_In is high and not yet accepted retargets the beat.

## Configuration
- DEMUX_DROP_COUNT_EN defined: Drop_Count_Out port and a 16-bit counter exist. The counter increments on each discarded beat and saturates at 16'hFFFF.
- Not defined: port and counter are absent; Drop_Pulse_Out still operates.

## Test plan
- Addressed fill/drain: CHANNELS=8, DATA_WIDTH=8, Mode 0, send 0xA5 to Select 3 with all DEMUX_Ready_In=0 → cycle+1 DEMUX_Valid_Out=8'b0000_1000, channel 3 data 0xA5. Then a second beat to Select 3 → Ready_Out=0 until DEMUX_Ready_In[3]=1.
- Full throughput: Mode 0, Select 5, DEMUX_Ready_In[5]=1, Valid_In held 10 cycles with data 0x00..0x09 → 10 accepts, consumer 5 sees 0x00..0x09 in order with no bubbles.
- Round-robin wrap: Mode 1, all consumers ready, 10 beats 0x10..0x19 → channels 0..7,0,1 receive them in order; rr_ptr = 2 afterwards. Switching to Mode 0 and back retains rr_ptr = 2.
- Out-of-range drop: CHANNELS=6, Mode 0, Select 7, Valid_In 3 cycles → Ready_Out=1, no DEMUX_Valid_Out change, Drop_Pulse_Out high 3 cycles. With DEMUX_DROP_COUNT_EN, Drop_Count_Out=3.
- Enable gating: Enable_In=0 with Valid_In=1 → Ready_Out=0. Pre-loaded channel 2 (0x3C) still drains when DEMUX_Ready_In[2]=1.
- Reset mid-operation: channels 0,4 loaded, rr_ptr=3, Reset_n_In low one edge → all outputs 0 next cycle. The first post-reset round-robin beat lands in channel 0.
